xs3_conv_seq: RTL and testbench
===============================

XS3_CONV_SEQ -- requirements
Module: xs3_conv_seq

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of 4-bit digits per word (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: request a conversion of din; accepted only when busy=0.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = BCD to Excess-3, 1 = Excess-3 to BCD; sampled with start.
REQ-006 The block SHALL have port din, input, 4*DIGITS bits: packed digits, digit 0 in bits [3:0].
REQ-007 The block SHALL have port busy, output, 1 bit: high from the accept edge until done is asserted.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse when dout and err_mask are valid.
REQ-009 The block SHALL have port dout, output, 4*DIGITS bits: converted word, held stable until the next accepted start.
REQ-010 The block SHALL have port err_mask, output, DIGITS bits: bit k set means digit k was invalid for the selected mode.

Function
REQ-011 The FSM SHALL have states IDLE, CONV and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch din and mode, clear the digit index, clear the working dout/err registers, and go to CONV.
REQ-013 CONV SHALL convert exactly one digit per cycle, LSD first (index 0..DIGITS-1), writing that digit's dout nibble and err_mask bit.
REQ-014 After the digit at index DIGITS-1 is converted, the FSM SHALL go to DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-015 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+DIGITS+1, and busy SHALL be low in that cycle.
REQ-016 Conversion in mode 0 SHALL be: valid BCD digit 0..9 maps to digit+3; digits 10..15 are invalid.
REQ-017 Conversion in mode 1 SHALL be: valid Excess-3 digit 3..12 maps to digit-3; digits 0..2 and 13..15 are invalid.
REQ-018 For an invalid digit, the output nibble SHALL be 4'hF and the corresponding err_mask bit SHALL be 1; the other digits SHALL still be converted.
REQ-019 All arithmetic SHALL be 4-bit, with no carry between digits and no wrap-around in valid ranges.
REQ-020 start while busy=1 SHALL be ignored; din and mode changes while busy SHALL NOT affect the result.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted, giving back-to-back throughput of one word per DIGITS+2 cycles.
REQ-022 With DIGITS=1, CONV SHALL last exactly one cycle.

Reset
REQ-023 When rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, dout=0, err_mask=0, index=0, latched mode/din=0.
REQ-024 Reset asserted in any state, including mid-CONV, SHALL abort the conversion; no done pulse SHALL follow.
REQ-025 Reset SHALL take priority over start on the same edge.

Structure
REQ-026 Package xs3_pkg SHALL hold the state enum (IDLE, CONV, DONE), XS3_OFFSET=3, BCD_MAX=9, XS3_MIN=3, XS3_MAX=12 and ERR_NIBBLE=4'hF.
REQ-027 A single combinational sub-module xs3_digit SHALL convert one nibble (inputs: digit, mode; outputs: result, invalid); the top level SHALL instantiate it once and time-share it across digits.

Verification (DIGITS=4)
REQ-028 Scenario: mode=0, din=16'h1234, start pulse -> after 5 cycles done=1 for one cycle, dout=16'h4567, err_mask=4'b0000.
REQ-029 Scenario: mode=0, din=16'h9870 -> dout=16'hCBA3; then mode=1, din=16'hCBA3 -> dout=16'h9870, err_mask=0.
REQ-030 Scenario: mode=0, din=16'h12A4 -> dout=16'h45F7, err_mask=4'b0010; mode=1, din=16'h0F45 -> dout=16'hFF12, err_mask=4'b1100.
REQ-031 Scenario: start with din=16'h1111, then start again with din=16'h2222 two cycles later while busy -> one done only, dout=16'h4444.
REQ-032 Scenario: rst_n=0 during cycle 2 of CONV -> next edge busy=0, dout=0, err_mask=0, no done pulse; a new start after reset converts correctly.
REQ-033 Scenario: back-to-back starts (start held high) -> done pulses spaced exactly 6 cycles apart, each with the correct dout.

Source files
------------

// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD <-> Excess-3 sequential converter.
// Holds the FSM state enum, digit range limits and the error nibble.
package xs3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] XS3_MIN    = 4'd3;
   localparam logic [3:0] XS3_MAX    = 4'd12;
   localparam logic [3:0] ERR_NIBBLE = 4'hF;

   // Index counter width; a single-digit word still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xs3_digit.sv
// Single-nibble converter: BCD -> Excess-3 (mode 0) or Excess-3 -> BCD (mode 1).
// Purely combinational; out-of-range digits yield ERR_NIBBLE with invalid set.
module xs3_digit
   import xs3_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       mode,
   output logic [3:0] result,
   output logic       invalid
);

   always_comb begin
      if (mode) begin
         invalid = (digit < XS3_MIN) || (digit > XS3_MAX);
         result  = invalid ? ERR_NIBBLE : (digit - XS3_OFFSET);
      end else begin
         invalid = (digit > BCD_MAX);
         result  = invalid ? ERR_NIBBLE : (digit + XS3_OFFSET);
      end
   end

endmodule

// File: rtl/xs3_conv_seq.sv
// Sequential multi-digit BCD/Excess-3 converter, one digit per cycle, LSD first.
// A single xs3_digit instance is time-shared across all digit positions.
module xs3_conv_seq
   import xs3_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [4*DIGITS-1:0]   din,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   dout,
   output logic [DIGITS-1:0]     err_mask
);

   localparam int IW = idx_width(DIGITS);
   localparam int W  = 4 * DIGITS;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              mode_q, mode_d;
   logic [W-1:0]      din_q, din_d;
   logic [W-1:0]      dout_q, dout_d;
   logic [DIGITS-1:0] err_q, err_d;
   logic              done_q, done_d;

   logic [3:0]        cur_digit;
   logic [3:0]        cur_result;
   logic              cur_invalid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         din_q   <= '0;
         dout_q  <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Select the nibble currently being converted from the latched word.
   always_comb begin
      cur_digit = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) cur_digit = din_q[k*4 +: 4];
      end
   end

   xs3_digit u_digit (
      .digit   (cur_digit),
      .mode    (mode_q),
      .result  (cur_result),
      .invalid (cur_invalid)
   );

   // done is registered off DONE so it appears in the first IDLE cycle, with busy low.
   always_comb begin
      idx_d  = idx_q;
      mode_d = mode_q;
      din_d  = din_q;
      dout_d = dout_q;
      err_d  = err_q;
      done_d = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode;
               din_d  = din;
               idx_d  = '0;
               dout_d = '0;
               err_d  = '0;
            end
         end
         CONV: begin
            for (int k = 0; k < DIGITS; k++) begin
               if (idx_q == IW'(k)) begin
                  dout_d[k*4 +: 4] = cur_result;
                  err_d[k]         = cur_invalid;
               end
            end
            if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      done     = done_q;
      dout     = dout_q;
      err_mask = err_q;
   end

endmodule

// File: tb/tb_xs3_conv_seq.sv
// Self-checking bench for xs3_conv_seq (DIGITS=4): a cycle-timed reference model
// plus hand-computed expectations for each converted word.
module tb_xs3_conv_seq;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic [W-1:0] din = '0;
   logic         busy, done;
   logic [W-1:0] dout;
   logic [D-1:0] err_mask;

   xs3_conv_seq #(.DIGITS(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .dout     (dout),
      .err_mask (err_mask)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Hand-computed expectations, filled by stimulus, consumed in done order.
   logic [W-1:0] lit_dout [0:31];
   logic [D-1:0] lit_err  [0:31];
   int           n_lit = 0;
   logic         fin = 1'b0;

   // Reference conversion straight from the digit rules.
   function automatic logic [W+D-1:0] ref_conv(input logic m, input logic [W-1:0] w);
      logic [W-1:0] o;
      logic [D-1:0] e;
      int v;
      o = '0;
      e = '0;
      for (int k = 0; k < D; k++) begin
         v = int'((w >> (4*k)) & 16'hF);
         if (m == 1'b0 && v <= 9)                o[4*k +: 4] = 4'(v + 3);
         else if (m == 1'b1 && v >= 3 && v <= 12) o[4*k +: 4] = 4'(v - 3);
         else begin
            o[4*k +: 4] = 4'hF;
            e[k] = 1'b1;
         end
      end
      return {e, o};
   endfunction

   // Timing model: accepted at edge k when idle, done seen after edge k+D+1.
   int           cyc = 0;
   int           done_edge = 0;
   logic         m_on = 1'b0, pend = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic [W-1:0] m_dout = '0, x_dout = '0;
   logic [D-1:0] m_err = '0, x_err = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_on   <= 1'b1;
         pend   <= 1'b0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dout <= '0;
         m_err  <= '0;
      end else begin
         m_done <= 1'b0;
         if (pend && cyc == done_edge) begin
            m_done <= 1'b1;
            pend   <= 1'b0;
            m_busy <= 1'b0;
            m_dout <= x_dout;
            m_err  <= x_err;
         end else if (!m_busy && start) begin
            pend      <= 1'b1;
            m_busy    <= 1'b1;
            done_edge <= cyc + D + 1;
            {x_err, x_dout} <= ref_conv(mode, din);
            m_dout    <= '0;
            m_err     <= '0;
         end
      end
   end

   function automatic int bad(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
         return 1;
      end
      return 0;
   endfunction

   int lit_rd = 0;
   int dut_dones = 0;
   logic fin_seen = 1'b0;

   always @(negedge clk) begin
      if (m_on) begin
         checks += 2;
         errors += bad("busy", 32'(busy), 32'(m_busy));
         errors += bad("done", 32'(done), 32'(m_done));
         if (!m_busy) begin
            checks += 2;
            errors += bad("dout_model", 32'(dout), 32'(m_dout));
            errors += bad("err_model", 32'(err_mask), 32'(m_err));
         end
         if (m_done) begin
            if (lit_rd < n_lit) begin
               checks += 2;
               errors += bad("dout_literal", 32'(dout), 32'(lit_dout[lit_rd]));
               errors += bad("err_literal", 32'(err_mask), 32'(lit_err[lit_rd]));
            end
            lit_rd++;
         end
         if (done) dut_dones++;
         if (fin && !fin_seen) begin
            fin_seen = 1'b1;
            checks += 1;
            errors += bad("done_count", 32'(dut_dones), 32'(n_lit));
         end
      end
   end

   task automatic expect_word(input logic [W-1:0] d, input logic [D-1:0] e);
      lit_dout[n_lit] = d;
      lit_err[n_lit]  = e;
      n_lit++;
   endtask

   task automatic pulse(input logic m, input logic [W-1:0] d);
      @(posedge clk); #1;
      mode = m; din = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      din = ~d;
      mode = ~m;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic go(input logic m, input logic [W-1:0] d,
                     input logic [W-1:0] xd, input logic [D-1:0] xe);
      expect_word(xd, xe);
      pulse(m, d);
      wait_done();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      go(1'b0, 16'h1234, 16'h4567, 4'b0000);
      go(1'b0, 16'h9870, 16'hCBA3, 4'b0000);
      go(1'b1, 16'hCBA3, 16'h9870, 4'b0000);
      go(1'b0, 16'h12A4, 16'h45F7, 4'b0010);
      go(1'b1, 16'h0F45, 16'hFF12, 4'b1100);
      go(1'b1, 16'h3C2D, 16'h09FF, 4'b0011);
      go(1'b0, 16'hF90A, 16'hFC3F, 4'b1001);

      // Second start while busy must be ignored.
      expect_word(16'h4444, 4'b0000);
      pulse(1'b0, 16'h1111);
      @(posedge clk); #1;
      start = 1'b1; din = 16'h2222; mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      repeat (3) @(posedge clk);

      // Reset in the second CONV cycle aborts the word.
      pulse(1'b0, 16'h5555);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      go(1'b1, 16'h8765, 16'h5432, 4'b0000);

      // start held high: three words, done every D+2 cycles.
      expect_word(16'h7654, 4'b0000);
      expect_word(16'h7654, 4'b0000);
      expect_word(16'h7654, 4'b0000);
      @(posedge clk); #1;
      mode = 1'b0; din = 16'h4321; start = 1'b1;
      repeat (13) @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);

      fin = 1'b1;
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
